// File: rtl/cpu_memory_bus.sv
// rtl/cpu_memory_bus.sv - stack CPU memory stage (3a -> 4a) with strobe/ack I/O bus
//
// Resolves branch kill/target, selects the stack push value and pop count, and
// runs single-beat load/store transactions on the I/O bus.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   valid_3a, stall_3a           upstream live flag / hold request (combinational)
//   c__branch_3a, c__to_push_3a,
//   c__mem_3a                    decoded control from the ALU stage
//   alu__cond_3a, alu__out_3a    ALU condition and result
//   instruction_3a, pc_3a,
//   r0_3a, r1_3a, st__to_pop_3a  operands from the ALU stage
//   bus__*                       I/O bus: address, write data, strobes, ack, read data
//   *_4a                         registered results for the stack writeback stage
module cpu_memory_bus #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 3,
    parameter int INSN_W   = 48,
    parameter int ADDR_W   = 8,
    parameter int POP_W    = 11,
    parameter int TYPE_INT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_3a,
    output logic                    stall_3a,
    input  logic [1:0]              c__branch_3a,
    input  logic [2:0]              c__to_push_3a,
    input  logic [1:0]              c__mem_3a,
    input  logic                    alu__cond_3a,
    input  logic [DATA_W-1:0]       alu__out_3a,
    input  logic [INSN_W-1:0]       instruction_3a,
    input  logic [DATA_W-1:0]       pc_3a,
    input  logic [TAG_W+DATA_W-1:0] r0_3a,
    input  logic [TAG_W+DATA_W-1:0] r1_3a,
    input  logic [POP_W-1:0]        st__to_pop_3a,
    output logic [ADDR_W-1:0]       bus__address,
    output logic [DATA_W-1:0]       bus__wrdata,
    output logic                    bus__rdstrobe,
    output logic                    bus__wrstrobe,
    input  logic                    bus__ack,
    input  logic [DATA_W-1:0]       bus__rddata,
    output logic                    valid_4a,
    output logic                    kill_4a,
    output logic                    err_4a,
    output logic [DATA_W-1:0]       branch_target_4a,
    output logic [DATA_W-1:0]       pc_4a,
    output logic [2:0]              c__to_push_4a,
    output logic [TAG_W+DATA_W-1:0] st__to_push_4a,
    output logic [POP_W-1:0]        st__to_pop_4a
);
    localparam int ENT_W = TAG_W + DATA_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                op_read_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rd_q, rd_next;

    logic mem_op, accept_mem, timeout, complete;
    logic kill_d;
    logic [DATA_W-1:0] target_d;
    logic [ENT_W-1:0]  push_d;
    logic [POP_W-1:0]  pop_d;
    logic unused_insn_bits;

    // Code 3 on c__mem_3a is reserved and behaves as no memory op.
    assign mem_op     = (c__mem_3a == 2'd1) || (c__mem_3a == 2'd2);
    assign accept_mem = (state_q == S_IDLE) && valid_3a && mem_op;
    assign timeout    = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT));
    assign complete   = ((state_q == S_IDLE) && valid_3a && !mem_op) ||
                        ((state_q == S_WAIT) && (bus__ack || timeout));

    assign unused_insn_bits = ^instruction_3a[INSN_W-1:ENT_W];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_mem) state_d = S_WAIT;
            S_WAIT:  if (bus__ack || timeout) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        stall_3a      = accept_mem || ((state_q == S_WAIT) && !bus__ack && !timeout);
        bus__rdstrobe = (state_q == S_WAIT) && op_read_q;
        bus__wrstrobe = (state_q == S_WAIT) && !op_read_q;
    end

    // Read data seen by this cycle's push: fresh bus data on a read ack,
    // all-ones on timeout, otherwise the last captured value.
    always_comb begin
        rd_next = rd_q;
        if ((state_q == S_WAIT) && bus__ack && op_read_q) rd_next = bus__rddata;
        else if (timeout && !bus__ack)                    rd_next = '1;
    end

    always_comb begin
        kill_d   = 1'b0;
        target_d = '0;
        case (c__branch_3a)
            2'd1: begin
                kill_d   = 1'b1;
                target_d = pc_3a + {{(DATA_W-16){instruction_3a[15]}}, instruction_3a[15:0]};
            end
            2'd2: begin
                kill_d   = alu__cond_3a;
                target_d = pc_3a + {{(DATA_W-16){instruction_3a[15]}}, instruction_3a[15:0]};
            end
            2'd3: begin
                kill_d   = 1'b1;
                target_d = alu__out_3a;
            end
            default: ;
        endcase

        push_d = '0;
        case (c__to_push_3a)
            3'd1:    push_d = {TAG_W'(TYPE_INT), alu__out_3a};
            3'd2:    push_d = instruction_3a[ENT_W-1:0];
            3'd3:    push_d = r0_3a;
            3'd4:    push_d = r1_3a;
            3'd5:    push_d = {TAG_W'(TYPE_INT), rd_next};
            default: push_d = '0;
        endcase

        // A pop count of 3 means "dynamic": the count comes from the ALU.
        pop_d = (st__to_pop_3a == POP_W'(3)) ? alu__out_3a[POP_W-1:0] : st__to_pop_3a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_read_q        <= 1'b0;
            cnt_q            <= '0;
            rd_q             <= '0;
            bus__address     <= '0;
            bus__wrdata      <= '0;
            valid_4a         <= 1'b0;
            kill_4a          <= 1'b0;
            err_4a           <= 1'b0;
            branch_target_4a <= '0;
            pc_4a            <= '0;
            c__to_push_4a    <= '0;
            st__to_push_4a   <= '0;
            st__to_pop_4a    <= '0;
        end else begin
            if (accept_mem) begin
                op_read_q    <= (c__mem_3a == 2'd1);
                cnt_q        <= '0;
                bus__address <= alu__out_3a[ADDR_W-1:0];
                bus__wrdata  <= r0_3a[DATA_W-1:0];
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            rd_q     <= rd_next;
            valid_4a <= complete;
            if (complete) begin
                kill_4a          <= kill_d;
                err_4a           <= timeout && !bus__ack;
                branch_target_4a <= target_d;
                pc_4a            <= pc_3a;
                c__to_push_4a    <= c__to_push_3a;
                st__to_push_4a   <= push_d;
                st__to_pop_4a    <= pop_d;
            end
        end
    end
endmodule

// File: tb/tb_cpu_memory_bus.sv
// tb/tb_cpu_memory_bus.sv - directed self-checking bench for cpu_memory_bus
module tb_cpu_memory_bus;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_3a = 1'b0;
    logic        stall_3a;
    logic [1:0]  c__branch_3a = '0;
    logic [2:0]  c__to_push_3a = '0;
    logic [1:0]  c__mem_3a = '0;
    logic        alu__cond_3a = 1'b0;
    logic [31:0] alu__out_3a = '0;
    logic [47:0] instruction_3a = '0;
    logic [31:0] pc_3a = '0;
    logic [34:0] r0_3a = '0;
    logic [34:0] r1_3a = '0;
    logic [10:0] st__to_pop_3a = '0;
    logic [7:0]  bus__address;
    logic [31:0] bus__wrdata;
    logic        bus__rdstrobe, bus__wrstrobe;
    logic        bus__ack = 1'b0;
    logic [31:0] bus__rddata = '0;
    logic        valid_4a, kill_4a, err_4a;
    logic [31:0] branch_target_4a, pc_4a;
    logic [2:0]  c__to_push_4a;
    logic [34:0] st__to_push_4a;
    logic [10:0] st__to_pop_4a;

    int passed = 0;
    int total  = 0;
    int wr_cycles;
    int stall_cycles;
    int rd_cycles;
    logic done;

    always #5 clk = ~clk;

    cpu_memory_bus #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_3a(valid_3a), .stall_3a(stall_3a),
        .c__branch_3a(c__branch_3a), .c__to_push_3a(c__to_push_3a), .c__mem_3a(c__mem_3a),
        .alu__cond_3a(alu__cond_3a), .alu__out_3a(alu__out_3a),
        .instruction_3a(instruction_3a), .pc_3a(pc_3a), .r0_3a(r0_3a), .r1_3a(r1_3a),
        .st__to_pop_3a(st__to_pop_3a), .bus__address(bus__address), .bus__wrdata(bus__wrdata),
        .bus__rdstrobe(bus__rdstrobe), .bus__wrstrobe(bus__wrstrobe), .bus__ack(bus__ack),
        .bus__rddata(bus__rddata), .valid_4a(valid_4a), .kill_4a(kill_4a), .err_4a(err_4a),
        .branch_target_4a(branch_target_4a), .pc_4a(pc_4a), .c__to_push_4a(c__to_push_4a),
        .st__to_push_4a(st__to_push_4a), .st__to_pop_4a(st__to_pop_4a)
    );

    task automatic check(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        if (ok) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        next_cycle();
        next_cycle();
        #3;
        check("rst_valid_4a", valid_4a === 1'b0, 64'(valid_4a), 64'(0));
        check("rst_kill_4a", kill_4a === 1'b0, 64'(kill_4a), 64'(0));
        check("rst_err_4a", err_4a === 1'b0, 64'(err_4a), 64'(0));
        check("rst_push_4a", st__to_push_4a === 35'h0, 64'(st__to_push_4a), 64'(0));
        check("rst_address", bus__address === 8'h0, 64'(bus__address), 64'(0));
        check("rst_rdstrobe", bus__rdstrobe === 1'b0, 64'(bus__rdstrobe), 64'(0));
        check("rst_wrstrobe", bus__wrstrobe === 1'b0, 64'(bus__wrstrobe), 64'(0));
        check("rst_stall", stall_3a === 1'b0, 64'(stall_3a), 64'(0));

        next_cycle();
        rst = 1'b0;
        valid_3a = 1'b1; c__branch_3a = 2'd1; pc_3a = 32'h100; instruction_3a = 48'hFFF0;
        #3;
        check("rel_stall", stall_3a === 1'b0, 64'(stall_3a), 64'(0));
        next_cycle();
        c__branch_3a = 2'd2; alu__cond_3a = 1'b0;
        #3;
        check("rel_valid_4a", valid_4a === 1'b1, 64'(valid_4a), 64'(1));
        check("rel_kill", kill_4a === 1'b1, 64'(kill_4a), 64'(1));
        check("rel_target", branch_target_4a === 32'hF0, 64'(branch_target_4a), 64'(32'hF0));
        check("rel_pc_4a", pc_4a === 32'h100, 64'(pc_4a), 64'(32'h100));
        next_cycle();
        c__branch_3a = 2'd3; alu__out_3a = 32'hCAFE;
        #3;
        check("relc_kill", kill_4a === 1'b0, 64'(kill_4a), 64'(0));
        check("relc_target", branch_target_4a === 32'hF0, 64'(branch_target_4a), 64'(32'hF0));
        next_cycle();
        c__branch_3a = 2'd0; c__to_push_3a = 3'd1; alu__out_3a = 32'h1234; st__to_pop_3a = 11'd3;
        #3;
        check("alu_br_kill", kill_4a === 1'b1, 64'(kill_4a), 64'(1));
        check("alu_br_target", branch_target_4a === 32'hCAFE, 64'(branch_target_4a), 64'(32'hCAFE));
        next_cycle();
        c__to_push_3a = 3'd2; instruction_3a = 48'h0007_8765_4321; st__to_pop_3a = 11'd5;
        #3;
        check("pushalu_value", st__to_push_4a === 35'h1_0000_1234, 64'(st__to_push_4a), 64'(35'h1_0000_1234));
        check("pushalu_pop", st__to_pop_4a === 11'h234, 64'(st__to_pop_4a), 64'(11'h234));
        check("pushalu_kill", kill_4a === 1'b0, 64'(kill_4a), 64'(0));
        check("pushalu_target", branch_target_4a === 32'h0, 64'(branch_target_4a), 64'(0));
        check("pushalu_code", c__to_push_4a === 3'd1, 64'(c__to_push_4a), 64'(1));
        next_cycle();
        valid_3a = 1'b0;
        #3;
        check("pushimm_value", st__to_push_4a === 35'h7_8765_4321, 64'(st__to_push_4a), 64'(35'h7_8765_4321));
        check("pushimm_pop", st__to_pop_4a === 11'd5, 64'(st__to_pop_4a), 64'(5));
        next_cycle();
        #3;
        check("bubble_valid_4a", valid_4a === 1'b0, 64'(valid_4a), 64'(0));
        check("bubble_hold", st__to_push_4a === 35'h7_8765_4321, 64'(st__to_push_4a), 64'(35'h7_8765_4321));

        next_cycle();
        valid_3a = 1'b1; c__mem_3a = 2'd1; c__to_push_3a = 3'd5; alu__out_3a = 32'h42;
        st__to_pop_3a = 11'd0;
        stall_cycles = 0; rd_cycles = 0;
        #3;
        check("rd_strobe_early", bus__rdstrobe === 1'b0, 64'(bus__rdstrobe), 64'(0));
        if (stall_3a) stall_cycles++;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 2) begin bus__ack = 1'b1; bus__rddata = 32'hDEADBEEF; end
            #3;
            if (stall_3a) stall_cycles++;
            if (bus__rdstrobe) rd_cycles++;
            check("rd_address", bus__address === 8'h42, 64'(bus__address), 64'(8'h42));
            check("rd_no_wr", bus__wrstrobe === 1'b0, 64'(bus__wrstrobe), 64'(0));
        end
        check("rd_stall_cycles", stall_cycles === 3, 64'(stall_cycles), 64'(3));
        check("rd_strobe_cycles", rd_cycles === 3, 64'(rd_cycles), 64'(3));
        next_cycle();
        bus__ack = 1'b0; valid_3a = 1'b0; c__mem_3a = 2'd0;
        #3;
        check("rd_valid_4a", valid_4a === 1'b1, 64'(valid_4a), 64'(1));
        check("rd_push", st__to_push_4a === 35'h1_DEAD_BEEF, 64'(st__to_push_4a), 64'(35'h1_DEAD_BEEF));
        check("rd_err", err_4a === 1'b0, 64'(err_4a), 64'(0));
        check("rd_strobe_after", bus__rdstrobe === 1'b0, 64'(bus__rdstrobe), 64'(0));

        next_cycle();
        valid_3a = 1'b1; c__mem_3a = 2'd2; c__to_push_3a = 3'd0; r0_3a = 35'h55;
        alu__out_3a = 32'h10;
        #3;
        check("wr_stall_accept", stall_3a === 1'b1, 64'(stall_3a), 64'(1));
        wr_cycles = 0; done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            next_cycle();
            #3;
            if (i == 0) begin
                check("wr_data", bus__wrdata === 32'h55, 64'(bus__wrdata), 64'(32'h55));
                check("wr_address", bus__address === 8'h10, 64'(bus__address), 64'(8'h10));
            end
            if (bus__wrstrobe) wr_cycles++;
            if (!stall_3a) done = 1'b1;
        end
        check("wr_timeout_done", done === 1'b1, 64'(done), 64'(1));
        check("wr_strobe_cycles", wr_cycles === 5, 64'(wr_cycles), 64'(5));
        next_cycle();
        c__mem_3a = 2'd0; c__to_push_3a = 3'd1; alu__out_3a = 32'h77;
        #3;
        check("to_valid_4a", valid_4a === 1'b1, 64'(valid_4a), 64'(1));
        check("to_err", err_4a === 1'b1, 64'(err_4a), 64'(1));
        check("to_wrstrobe", bus__wrstrobe === 1'b0, 64'(bus__wrstrobe), 64'(0));
        check("to_next_stall", stall_3a === 1'b0, 64'(stall_3a), 64'(0));
        next_cycle();
        valid_3a = 1'b0;
        #3;
        check("after_to_valid", valid_4a === 1'b1, 64'(valid_4a), 64'(1));
        check("after_to_err", err_4a === 1'b0, 64'(err_4a), 64'(0));
        check("after_to_push", st__to_push_4a === 35'h1_0000_0077, 64'(st__to_push_4a), 64'(35'h1_0000_0077));

        next_cycle();
        valid_3a = 1'b1; c__mem_3a = 2'd1; c__to_push_3a = 3'd5; alu__out_3a = 32'h99;
        next_cycle();
        #3;
        check("rw_strobe", bus__rdstrobe === 1'b1, 64'(bus__rdstrobe), 64'(1));
        check("rw_address", bus__address === 8'h99, 64'(bus__address), 64'(8'h99));
        next_cycle();
        rst = 1'b1; valid_3a = 1'b0; c__mem_3a = 2'd0;
        next_cycle();
        rst = 1'b0; bus__ack = 1'b1; bus__rddata = 32'h0BAD;
        #3;
        check("rw_rdstrobe", bus__rdstrobe === 1'b0, 64'(bus__rdstrobe), 64'(0));
        check("rw_valid_4a", valid_4a === 1'b0, 64'(valid_4a), 64'(0));
        check("rw_stall", stall_3a === 1'b0, 64'(stall_3a), 64'(0));
        check("rw_address_clr", bus__address === 8'h0, 64'(bus__address), 64'(0));
        check("rw_push_clr", st__to_push_4a === 35'h0, 64'(st__to_push_4a), 64'(0));
        next_cycle();
        bus__ack = 1'b0;
        #3;
        check("late_ack_valid", valid_4a === 1'b0, 64'(valid_4a), 64'(0));
        check("late_ack_strobe", bus__rdstrobe === 1'b0, 64'(bus__rdstrobe), 64'(0));

        next_cycle();
        valid_3a = 1'b1; c__mem_3a = 2'd1; c__to_push_3a = 3'd5; alu__out_3a = 32'h20;
        next_cycle();
        bus__ack = 1'b1; bus__rddata = 32'h1111_1111;
        #3;
        check("b2b1_strobe", bus__rdstrobe === 1'b1, 64'(bus__rdstrobe), 64'(1));
        check("b2b1_stall", stall_3a === 1'b0, 64'(stall_3a), 64'(0));
        next_cycle();
        bus__ack = 1'b0; alu__out_3a = 32'h21;
        #3;
        check("b2b_gap", bus__rdstrobe === 1'b0, 64'(bus__rdstrobe), 64'(0));
        check("b2b1_valid", valid_4a === 1'b1, 64'(valid_4a), 64'(1));
        check("b2b1_push", st__to_push_4a === 35'h1_1111_1111, 64'(st__to_push_4a), 64'(35'h1_1111_1111));
        check("b2b2_stall", stall_3a === 1'b1, 64'(stall_3a), 64'(1));
        next_cycle();
        bus__ack = 1'b1; bus__rddata = 32'h2222_2222;
        #3;
        check("b2b2_strobe", bus__rdstrobe === 1'b1, 64'(bus__rdstrobe), 64'(1));
        check("b2b2_address", bus__address === 8'h21, 64'(bus__address), 64'(8'h21));
        check("b2b2_no_valid", valid_4a === 1'b0, 64'(valid_4a), 64'(0));
        next_cycle();
        bus__ack = 1'b0; valid_3a = 1'b0; c__mem_3a = 2'd0;
        #3;
        check("b2b2_valid", valid_4a === 1'b1, 64'(valid_4a), 64'(1));
        check("b2b2_push", st__to_push_4a === 35'h1_2222_2222, 64'(st__to_push_4a), 64'(35'h1_2222_2222));
        check("b2b2_err", err_4a === 1'b0, 64'(err_4a), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cpu_memory_bus.md
# cpu_memory_bus

Parametrised memory stage of the stack CPU pipeline (3a → 4a). It resolves branches (target and kill), selects the stack push value, and resolves the pop count. It also runs load/store transactions on the I/O bus using a strobe/ack handshake, with upstream stall and a timeout. It replaces the fixed-width, bus-less memory stage and sits between the ALU stage (3a) and the stack writeback stage (4a).

## Interface
Parameters:
- `DATA_W`, 32: data/PC/ALU width
- `TAG_W`, 3: stack-entry type tag width; stack entry = `TAG_W+DATA_W`
- `INSN_W`, 48: instruction width
- `ADDR_W`, 8: bus address width
- `POP_W`, 11: pop-count width
- `TYPE_INT`, 1: tag value applied to ALU/bus results
- `TIMEOUT`, 255: max cycles to wait for `bus__ack` (≥1)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `valid_3a` in 1: 3a holds a live instruction
- `stall_3a` out 1: upstream must hold all 3a inputs stable
- `c__branch_3a` in 2: 0 NONE, 1 REL, 2 REL_COND, 3 ALU
- `c__to_push_3a` in 3: 0 NONE, 1 ALU, 2 IMM, 3 REG0, 4 REG1, 5 BUS
- `c__mem_3a` in 2: 0 NONE, 1 READ, 2 WRITE, 3 reserved (treated as NONE)
- `alu__cond_3a` in 1: branch condition
- `alu__out_3a` in DATA_W: ALU result / bus address / dynamic pop count
- `instruction_3a` in INSN_W: bits [15:0] rel offset; bits [TAG_W+DATA_W-1:0] push immediate
- `pc_3a` in DATA_W; `r0_3a`, `r1_3a` in TAG_W+DATA_W; `st__to_pop_3a` in POP_W
- `bus__address` out ADDR_W; `bus__wrdata` out DATA_W
- `bus__rdstrobe`, `bus__wrstrobe` out 1; `bus__ack` in 1; `bus__rddata` in DATA_W
- `valid_4a`, `kill_4a`, `err_4a` out 1
- `branch_target_4a`, `pc_4a` out DATA_W
- `c__to_push_4a` out 3; `st__to_push_4a` out TAG_W+DATA_W; `st__to_pop_4a` out POP_W

## Operation
- All 4a outputs are registered and load only on a *completing* cycle: `valid_3a` & no mem op in IDLE, or WAIT & (`bus__ack` | timeout). On any other cycle, `valid_4a` goes to 0 and the other 4a outputs hold.
- **Kill:** 0 for NONE, 1 for REL/ALU, `alu__cond_3a` for REL_COND.
- **Branch target:** REL/REL_COND → `pc_3a` + sign-extended `instruction_3a[15:0]` (mod 2^DATA_W). ALU → `alu__out_3a`. NONE → 0.
- **Push value:**
  - ALU → `{TYPE_INT, alu__out_3a}`
  - IMM → `instruction_3a[TAG_W+DATA_W-1:0]`
  - REG0/REG1 → `r0_3a` / `r1_3a`
  - BUS → `{TYPE_INT, captured read data}`
  - NONE and codes 6–7 → 0
- **Pop:** if `st__to_pop_3a == 3`, output `alu__out_3a[POP_W-1:0]`; otherwise pass through. `pc_4a` and `c__to_push_4a` pass through.
- **FSM IDLE:**
  - `valid_3a` & READ/WRITE → go to WAIT and latch address = `alu__out_3a[ADDR_W-1:0]`, wrdata = `r0_3a[DATA_W-1:0]`; clear wait counter.
- **FSM WAIT:**
  - Exactly one strobe is high (rd for READ, wr for WRITE), held until the completing cycle. Address and wrdata are held constant.
  - Counter increments each cycle.
  - `bus__ack` → capture `bus__rddata` (READ), `err_4a`=0, go to IDLE.
  - Counter == TIMEOUT without ack → complete with read data all-ones, `err_4a`=1, go to IDLE.
- `err_4a`=0 on all non-bus completions.
- `stall_3a` = (IDLE & `valid_3a` & mem op) | (WAIT & !`bus__ack` & !timeout). This is combinational.
- Ack seen in IDLE is ignored.
- `valid_3a`=0 in IDLE → no action.

## Timing
- Non-mem instruction accepted at edge N → `valid_4a`=1 in cycle N+1.
- Mem op presented in cycle N:
  - Strobe is high from cycle N+1.
  - Ack in cycle N+k (k≥1) → `stall_3a` low in N+k; `valid_4a`, data and `err_4a` present in N+k+1; strobe low in N+k+1.
- Timeout fires in cycle N+1+TIMEOUT when no ack has arrived.
- Back-to-back mem ops: the second is accepted in the cycle after completion (IDLE). The strobe has at least one low cycle between transactions.
- Reset (any state, including WAIT mid-transaction):
  - Next cycle: state IDLE, strobes 0, counter 0.
  - Every 4a output = 0; `bus__address` = 0; `bus__wrdata` = 0.
  - The in-flight transaction is abandoned.

## Test plan
- REL branch, `pc_3a`=0x100, imm=0xFFF0 → `branch_target_4a`=0xF0, `kill_4a`=1, `valid_4a`=1 one cycle later. REL_COND with cond=0 → `kill_4a`=0.
- PUSHALU with `alu__out_3a`=0x1234, `st__to_pop_3a`=3 → `st__to_push_4a`={1,0x1234}, `st__to_pop_4a`=0x234 (POP_W=11).
- READ at address 0x42, ack 3 cycles after strobe with rddata 0xDEADBEEF, PUSHBUS:
  - `stall_3a` high for 3 cycles and `bus__rdstrobe` high for 3 cycles with address 0x42.
  - Then `st__to_push_4a`={1,0xDEADBEEF}, `err_4a`=0.
- WRITE, `r0_3a` data 0x55, never ack, TIMEOUT=4:
  - `bus__wrstrobe` high for exactly 5 cycles.
  - Then `valid_4a`=1, `err_4a`=1.
  - The next instruction is accepted.
- Assert `rst` while in WAIT → following cycle: strobes 0, `valid_4a`=0, `stall_3a`=0. A late `bus__ack` is ignored.
- Two back-to-back READs with immediate ack → strobe low for ≥1 cycle between them; two `valid_4a` pulses carrying their respective data.
